// File: rtl/result_emitter.sv
// result_emitter
//   Producer side of the result/capture-strobe interface feeding the display
//   block. A valid pulse latches four 2x2 result words; they are then emitted
//   in order 00, 01, 10, 11 on a shared bus, each framed by its own capture
//   strobe (setup cycle, STROBE_CYCLES strobe cycles, hold cycle).
//
//   Optional feature: define RESULT_SATURATE_EN to clamp oversized results
//   to the bus maximum instead of truncating them.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active-high
//   valid          array done pulse, r00..r11 valid in the same cycle
//   r00..r11       result words (row, col), IN_W bits unsigned
//   out            emitted data bus, OUT_W bits
//   c00..c11       capture strobes, one per result position
//   busy           high while a sequence is in progress
//   finished       one-cycle pulse after the fourth element completes
module result_emitter #(
    parameter int unsigned IN_W          = 16,
    parameter int unsigned OUT_W         = 8,
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [IN_W-1:0]  r00,
    input  logic [IN_W-1:0]  r01,
    input  logic [IN_W-1:0]  r10,
    input  logic [IN_W-1:0]  r11,
    output logic [OUT_W-1:0] out,
    output logic             c00,
    output logic             c01,
    output logic             c10,
    output logic             c11,
    output logic             busy,
    output logic             finished
);

    localparam int unsigned CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam int unsigned WIDE  = (IN_W > OUT_W) ? IN_W : OUT_W;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic [3:0]          strb_q, strb_d;
    logic                busy_q, busy_d;
    logic                fin_q, fin_d;
    logic                load;
    logic [IN_W-1:0]     res_q [4];

    // Map an IN_W result onto the OUT_W bus (clamp or wrap).
    function automatic logic [OUT_W-1:0] conv(input logic [IN_W-1:0] x);
`ifdef RESULT_SATURATE_EN
        logic [WIDE-1:0] sat_max;
        sat_max = WIDE'({OUT_W{1'b1}});
        if (WIDE'(x) > sat_max) begin
            return {OUT_W{1'b1}};
        end
        return OUT_W'(x);
`else
        return OUT_W'(x);
`endif
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        strb_d  = '0;
        busy_d  = busy_q;
        fin_d   = 1'b0;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid) begin
                    load    = 1'b1;
                    idx_d   = 2'd0;
                    out_d   = conv(r00);
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                strb_d  = 4'b0001 << idx_q;
                cnt_d   = '0;
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == CNT_W'(STROBE_CYCLES - 1)) begin
                    state_d = HOLD;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    strb_d = strb_q;
                end
            end
            HOLD: begin
                if (idx_q == 2'd3) begin
                    fin_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    // Next word goes on the bus now so it is stable through SETUP.
                    idx_d   = idx_q + 2'd1;
                    out_d   = conv(res_q[idx_q + 2'd1]);
                    state_d = SETUP;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, output and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            strb_q  <= '0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            strb_q  <= strb_d;
            busy_q  <= busy_d;
            fin_q   <= fin_d;
            if (load) begin
                res_q[0] <= r00;
                res_q[1] <= r01;
                res_q[2] <= r10;
                res_q[3] <= r11;
            end
        end
    end

    assign out      = out_q;
    assign c00      = strb_q[0];
    assign c01      = strb_q[1];
    assign c10      = strb_q[2];
    assign c11      = strb_q[3];
    assign busy     = busy_q;
    assign finished = fin_q;

endmodule

// File: tb/tb_result_emitter.sv
// Testbench for result_emitter: table of result vectors replayed through a
// scoreboard, plus hand-written timing, busy-drop, reset and back-to-back runs.
module tb_result_emitter;

    localparam int unsigned IN_W  = 16;
    localparam int unsigned OUT_W = 8;
    localparam int unsigned S     = 2;
    localparam int unsigned NVEC  = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid = 1'b0;
    logic [IN_W-1:0]  r00 = '0, r01 = '0, r10 = '0, r11 = '0;
    logic [OUT_W-1:0] out;
    logic             c00, c01, c10, c11, busy, finished;

    result_emitter #(.IN_W(IN_W), .OUT_W(OUT_W), .STROBE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .valid(valid),
        .r00(r00), .r01(r01), .r10(r10), .r11(r11),
        .out(out), .c00(c00), .c01(c01), .c10(c10), .c11(c11),
        .busy(busy), .finished(finished)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][IN_W-1:0]  r;
        logic [3:0][OUT_W-1:0] e;
    } vec_t;

    typedef struct {
        int idx;
        int val;
    } sb_t;

    vec_t vecs [NVEC];
    sb_t  sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [3:0]       prev_c = '0;
    logic [OUT_W-1:0] prev_out = '0;

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input int ea, input int eb, input int ec, input int ed);
        vec_t v;
        v.r[0] = IN_W'(a);  v.r[1] = IN_W'(b);  v.r[2] = IN_W'(c);  v.r[3] = IN_W'(d);
        v.e[0] = OUT_W'(ea); v.e[1] = OUT_W'(eb); v.e[2] = OUT_W'(ec); v.e[3] = OUT_W'(ed);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle strobe monitor: isolation, data stability, scoreboard pop on rising strobe.
    task automatic monitor();
        logic [3:0] cur;
        sb_t e;
        int ci;
        cur = {c11, c10, c01, c00};
        if (!rst) begin
            if (cur != 4'b0) begin
                check("strobe_onehot", int'($onehot0(cur)), 1);
                if (prev_c != 4'b0) check("out_stable_in_strobe", int'(out), int'(prev_out));
            end
            if ((cur & ~prev_c) != 4'b0) begin
                ci = 0;
                for (int k = 0; k < 4; k++) if (cur[k]) ci = k;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: strobe %0d rose with out=%0d, no element expected", ci, out);
                end else begin
                    e = sb.pop_front();
                    check("strobe_index", ci, e.idx);
                    check("strobe_data", int'(out), e.val);
                end
            end
        end
        prev_c   = cur;
        prev_out = out;
    endtask

    // Advance to just after the next rising edge and sample that cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic drive_vec(input int i);
        valid = 1'b1;
        r00 = vecs[i].r[0]; r01 = vecs[i].r[1]; r10 = vecs[i].r[2]; r11 = vecs[i].r[3];
        for (int k = 0; k < 4; k++) sb.push_back('{idx: k, val: int'(vecs[i].e[k])});
    endtask

    task automatic wait_finished();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (finished) seen = 1'b1;
        end
        check("finished_seen", int'(seen), 1);
    endtask

    task automatic run_seq(input int i);
        tick();
        drive_vec(i);
        tick();
        valid = 1'b0;
        wait_finished();
    endtask

    function automatic int exp_timing(input int t);
        logic [5:0] v;
        v = '0;
        v[5] = (t >= 1 && t <= 4 * (S + 2) + 1);
        v[4] = (t == 4 * (S + 2) + 1);
        for (int k = 0; k < 4; k++)
            v[k] = (t >= 2 + k * (S + 2)) && (t <= 1 + S + k * (S + 2));
        return int'(v);
    endfunction

    initial begin
        int nfin;

        vecs[0] = mk(1, 2, 3, 4, 1, 2, 3, 4);
`ifdef RESULT_SATURATE_EN
        vecs[1] = mk(300, 255, 256, 0, 255, 255, 255, 0);
        vecs[2] = mk(16'hFFFF, 16'h1234, 7, 128, 255, 255, 7, 128);
        vecs[3] = mk(16'h00AA, 16'h0155, 16'h8000, 1, 170, 255, 255, 1);
`else
        vecs[1] = mk(300, 255, 256, 0, 44, 255, 0, 0);
        vecs[2] = mk(16'hFFFF, 16'h1234, 7, 128, 255, 8'h34, 7, 128);
        vecs[3] = mk(16'h00AA, 16'h0155, 16'h8000, 1, 170, 8'h55, 0, 1);
`endif
        vecs[4] = mk(5, 6, 7, 8, 5, 6, 7, 8);

        // Reset state
        tick();
        tick();
        check("reset_out", int'(out), 0);
        check("reset_flags", int'({busy, finished, c11, c10, c01, c00}), 0);
        rst = 1'b0;
        tick();
        check("idle_flags", int'({busy, finished, c11, c10, c01, c00}), 0);

        // Table-driven conversion/ordering runs
        for (int i = 0; i < NVEC; i++) begin
            run_seq(i);
            tick();
            tick();
            check("out_holds_last", int'(out), int'(vecs[i].e[3]));
            check("sb_drained", sb.size(), 0);
        end

        // Exact cycle timing, then back-to-back accept right after DONE
        tick();
        drive_vec(0);
        for (int t = 1; t <= 4 * (S + 2) + 1; t++) begin
            tick();
            if (t == 1) valid = 1'b0;
            check($sformatf("timing_c%0d", t), int'({busy, finished, c11, c10, c01, c00}), exp_timing(t));
        end
        tick();
        check("b2b_idle_busy", int'(busy), 0);
        drive_vec(4);
        tick();
        valid = 1'b0;
        check("b2b_c00_cycle19", int'(c00), 0);
        check("b2b_busy_cycle19", int'(busy), 1);
        tick();
        check("b2b_c00_cycle20", int'(c00), 1);
        wait_finished();
        check("b2b_sb_drained", sb.size(), 0);

        // Valid while busy is ignored; a single finished pulse
        tick();
        drive_vec(0);
        nfin = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == 1) valid = 1'b0;
            if (t == 5) begin
                valid = 1'b1;
                r00 = 16'd9; r01 = 16'd9; r10 = 16'd9; r11 = 16'd9;
            end
            if (t == 6) valid = 1'b0;
            if (finished) nfin++;
        end
        check("busy_valid_one_finish", nfin, 1);
        check("busy_valid_sb_drained", sb.size(), 0);
        check("busy_valid_out_last", int'(out), 4);

        // Asynchronous reset during c01
        tick();
        drive_vec(0);
        for (int t = 1; t <= 7; t++) begin
            tick();
            if (t == 1) valid = 1'b0;
        end
        check("pre_reset_c01", int'(c01), 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_c01", int'(c01), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_out", int'(out), 0);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        run_seq(0);
        check("post_reset_sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
